// File: rtl/multicycle_dmem.sv
// Multi-cycle data memory with byte/halfword/word access and fixed response latency.
// Access-fault detection is compiled in only when MULTICYCLE_DMEM_FAULT_EN is defined.
module multicycle_dmem #(
  parameter int MEM_DEPTH = 16384,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic        write_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q;
  logic [31:0] mem [MEM_DEPTH];

  logic        accept, enter_resp, leave_resp;
  logic        cur_write, cur_uns, fault;
  logic [1:0]  cur_size, lane;
  logic [31:0] cur_addr, cur_wdata;
  logic [IW-1:0] idx;
  logic [3:0]  be;
  logic [31:0] wword, rword, load_ext;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic        unused_addr;

  assign req_ready  = (state == S_IDLE) && !reset;
  assign resp_valid = (state == S_RESP) && !reset;
  assign resp_rdata = reset ? 32'd0 : rdata_q;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    enter_resp = 1'b0;
    leave_resp = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            enter_resp = 1'b1;
            state_next = S_RESP;
          end else begin
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // counter reaches 0 on the edge that enters RESP
        if (cnt <= 4'd1) begin
          enter_resp = 1'b1;
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          leave_resp = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= 4'd0;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      if (accept) begin
        cnt     <= 4'(LATENCY - 1);
        write_q <= req_write;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // With LATENCY=1 the access happens on the accept edge, so use live inputs in IDLE
  assign cur_write = (state == S_IDLE) ? req_write    : write_q;
  assign cur_uns   = (state == S_IDLE) ? req_unsigned : uns_q;
  assign cur_size  = (state == S_IDLE) ? req_size     : size_q;
  assign cur_addr  = (state == S_IDLE) ? req_addr     : addr_q;
  assign cur_wdata = (state == S_IDLE) ? req_wdata    : wdata_q;

  assign idx  = cur_addr[IW+1:2];
  assign lane = cur_addr[1:0];
  assign unused_addr = ^cur_addr[31:IW+2];

`ifdef MULTICYCLE_DMEM_FAULT_EN
  logic err_q;

  assign fault = (cur_size == 2'b01 && cur_addr[0]) ||
                 (cur_size[1] && cur_addr[1:0] != 2'b00) ||
                 ({2'b00, cur_addr[31:2]} >= 32'(MEM_DEPTH));

  always_ff @(posedge clk) begin
    if (reset)           err_q <= 1'b0;
    else if (enter_resp) err_q <= fault;
    else if (leave_resp) err_q <= 1'b0;
  end

  assign resp_err = err_q && !reset;
`else
  assign fault    = 1'b0;
  assign resp_err = 1'b0;
`endif

  always_comb begin
    be    = 4'b1111;
    wword = cur_wdata;
    case (cur_size)
      2'b00: begin
        be    = 4'b0001 << lane;
        wword = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        be    = cur_addr[1] ? 4'b1100 : 4'b0011;
        wword = {2{cur_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wword = cur_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 32'd0;
    end else if (enter_resp && cur_write && !fault) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
    end
  end

  assign rword = mem[idx];
  assign rbyte = rword[{lane, 3'b000} +: 8];
  assign rhalf = cur_addr[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    load_ext = rword;
    case (cur_size)
      2'b00:   load_ext = cur_uns ? {24'd0, rbyte} : {{24{rbyte[7]}}, rbyte};
      2'b01:   load_ext = cur_uns ? {16'd0, rhalf} : {{16{rhalf[15]}}, rhalf};
      default: load_ext = rword;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)           rdata_q <= 32'd0;
    else if (enter_resp) rdata_q <= (cur_write || fault) ? 32'd0 : load_ext;
    else if (leave_resp) rdata_q <= 32'd0;
  end

endmodule

// File: tb/tb_multicycle_dmem.sv
// Bench for multicycle_dmem: directed scenarios plus random traffic on two instances
// (LATENCY=2/depth 16384 and LATENCY=1/depth 16) against a byte-level memory model.
module tb_multicycle_dmem;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        valid_a, ready_a, rv_a, rr_a, err_a;
  logic        valid_b, ready_b, rv_b, rr_b, err_b;
  logic [31:0] rdata_a, rdata_b;

  int checks = 0;
  int failures = 0;
  bit [31:0] mem_a [int];
  bit [31:0] mem_b [int];

  always #5 clk = ~clk;

  multicycle_dmem #(.MEM_DEPTH(16384), .LATENCY(2)) dut_a (
    .clk(clk), .reset(reset), .req_valid(valid_a), .req_ready(ready_a),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .resp_valid(rv_a),
    .resp_ready(rr_a), .resp_rdata(rdata_a), .resp_err(err_a));

  multicycle_dmem #(.MEM_DEPTH(16), .LATENCY(1)) dut_b (
    .clk(clk), .reset(reset), .req_valid(valid_b), .req_ready(ready_b),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .resp_valid(rv_b),
    .resp_ready(rr_b), .resp_rdata(rdata_b), .resp_err(err_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic get_ready(input int inst);
    return (inst == 0) ? ready_a : ready_b;
  endfunction
  function automatic logic get_rv(input int inst);
    return (inst == 0) ? rv_a : rv_b;
  endfunction
  function automatic logic [31:0] get_rdata(input int inst);
    return (inst == 0) ? rdata_a : rdata_b;
  endfunction
  function automatic logic get_err(input int inst);
    return (inst == 0) ? err_a : err_b;
  endfunction

  // Byte-level reference: locate the touched bytes, then merge or gather them.
  task automatic model(input int inst, input bit wr, input bit [31:0] addr, input bit [1:0] size,
                       input bit uns, input bit [31:0] wdata,
                       output bit [31:0] exp_d, output bit exp_e);
    int depth, idx, lane, nb, first;
    bit [31:0] w;
    longint v;
    bit flt;
    depth = (inst == 0) ? 16384 : 16;
    flt = 1'b0;
`ifdef MULTICYCLE_DMEM_FAULT_EN
    flt = (size == 2'd1 && addr % 2 != 0) || (size >= 2'd2 && addr % 4 != 0) || (addr / 4 >= depth);
`endif
    idx   = int'((addr / 4) % depth);
    lane  = int'(addr % 4);
    nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    first = (size == 2'd0) ? lane : (size == 2'd1) ? (lane / 2) * 2 : 0;
    if (inst == 0) w = mem_a.exists(idx) ? mem_a[idx] : 32'd0;
    else           w = mem_b.exists(idx) ? mem_b[idx] : 32'd0;
    exp_d = 32'd0;
    exp_e = flt;
    if (flt) return;
    if (wr) begin
      for (int k = 0; k < nb; k++) w[8*(first+k) +: 8] = wdata[8*k +: 8];
      if (inst == 0) mem_a[idx] = w;
      else           mem_b[idx] = w;
    end else begin
      v = 0;
      for (int k = 0; k < nb; k++) v += longint'(w[8*(first+k) +: 8]) << (8*k);
      if (!uns && nb < 4 && v >= (longint'(1) << (8*nb - 1))) v -= longint'(1) << (8*nb);
      exp_d = v[31:0];
    end
  endtask

  task automatic set_valid(input int inst, input logic v);
    if (inst == 0) valid_a = v;
    else           valid_b = v;
  endtask
  task automatic set_rr(input int inst, input logic v);
    if (inst == 0) rr_a = v;
    else           rr_b = v;
  endtask

  // Called at a negedge with the target instance idle; returns at a negedge, idle again.
  task automatic do_req(input int inst, input bit wr, input bit [31:0] addr, input bit [1:0] size,
                        input bit uns, input bit [31:0] wdata, input int stall,
                        output bit [31:0] got);
    bit [31:0] exp_d;
    bit exp_e;
    int lat, n;
    logic [31:0] held;
    model(inst, wr, addr, size, uns, wdata, exp_d, exp_e);
    lat = (inst == 0) ? 2 : 1;
    check("req_ready_before", get_ready(inst), 1);
    req_write = wr; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
    set_valid(inst, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_valid(inst, 1'b0);
    req_write = 1'($urandom); req_addr = $urandom; req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_wdata = $urandom;
    n = 1;
    while (!get_rv(inst) && n < 20) begin
      check("req_ready_wait", get_ready(inst), 0);
      @(negedge clk);
      n++;
    end
    check("latency", n, lat);
    got  = get_rdata(inst);
    held = got;
    check("rdata", got, exp_d);
    check("err", get_err(inst), exp_e);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", get_rv(inst), 1);
      check("stall_rdata", get_rdata(inst), held);
      check("stall_ready", get_ready(inst), 0);
    end
    set_rr(inst, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_rr(inst, 1'b0);
    check("valid_after_hs", get_rv(inst), 0);
    check("ready_after_hs", get_ready(inst), 1);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("rst_ready_a", ready_a, 0);
      check("rst_valid_a", rv_a, 0);
      check("rst_rdata_a", rdata_a, 0);
      check("rst_err_a", err_a, 0);
      check("rst_valid_b", rv_b, 0);
    end
    mem_a.delete();
    mem_b.delete();
    reset = 1'b0;
    #1;
    check("ready_after_rst_a", ready_a, 1);
    check("ready_after_rst_b", ready_b, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bit [31:0] got;
    int inst;
    bit [31:0] addr;
    reset = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0; rr_a = 1'b0; rr_b = 1'b0;
    req_write = 1'b0; req_addr = 32'd0; req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 32'd0;
    @(negedge clk);
    do_reset(3);
    @(negedge clk);

    do_req(0, 1, 32'h10, 2'd2, 0, 32'hDEADBEEF, 0, got);
    check("store_word_rdata0", got, 32'h0);
    do_req(0, 0, 32'h10, 2'd2, 0, 32'h0, 0, got);
    check("load_word_10", got, 32'hDEADBEEF);
    do_req(0, 1, 32'h13, 2'd0, 0, 32'h0000005A, 0, got);
    do_req(0, 0, 32'h13, 2'd0, 0, 32'h0, 0, got);
    check("load_byte_13", got, 32'h0000005A);
    do_req(0, 0, 32'h10, 2'd2, 0, 32'h0, 0, got);
    check("load_word_merged", got, 32'h5AADBEEF);
    do_req(0, 1, 32'h11, 2'd0, 0, 32'hABCDEF80, 0, got);
    do_req(0, 0, 32'h11, 2'd0, 0, 32'h0, 0, got);
    check("load_byte_signed", got, 32'hFFFFFF80);
    do_req(0, 0, 32'h11, 2'd0, 1, 32'h0, 3, got);
    check("load_byte_unsigned", got, 32'h00000080);
    do_req(0, 0, 32'h12, 2'd1, 0, 32'h0, 2, got);
    check("load_half_signed", got, 32'h00005AAD);

    // Reset one cycle after a store is accepted discards it
    req_write = 1'b1; req_addr = 32'h20; req_size = 2'd2; req_unsigned = 1'b0; req_wdata = 32'h12345678;
    valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_a = 1'b0;
    do_reset(2);
    @(negedge clk);
    do_req(0, 0, 32'h20, 2'd2, 0, 32'h0, 0, got);
    check("aborted_store", got, 32'h0);

    do_req(0, 1, 32'h22, 2'd2, 0, 32'h11111111, 0, got);
    do_req(0, 0, 32'h20, 2'd2, 0, 32'h0, 0, got);
`ifdef MULTICYCLE_DMEM_FAULT_EN
    check("misaligned_word_store", got, 32'h0);
`else
    check("misaligned_word_store", got, 32'h11111111);
`endif

    do_req(1, 1, 32'h04, 2'd2, 0, 32'hCAFEF00D, 0, got);
    do_req(1, 0, 32'h44, 2'd2, 0, 32'h0, 1, got);
`ifdef MULTICYCLE_DMEM_FAULT_EN
    check("wrap_load_44", got, 32'h0);
`else
    check("wrap_load_44", got, 32'hCAFEF00D);
`endif

    for (int i = 0; i < 120; i++) begin
      inst = int'($urandom % 2);
      if (inst == 0) addr = (($urandom % 4 == 0) ? 32'h0001_0000 : 32'h0) + ($urandom % 64);
      else           addr = $urandom % 128;
      do_req(inst, 1'($urandom), addr, 2'($urandom), 1'($urandom), $urandom,
             int'($urandom % 3), got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_dmem.md
MULTICYCLE_DMEM -- requirements
Module: multicycle_dmem

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 16384, number of 32-bit words (power of 2, >=4).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request accept to response (1..15).
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  block can accept a request.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
REQ-010 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 SHALL have port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 SHALL have port resp_valid  output  1  response present.
REQ-013 SHALL have port resp_ready  input  1  consumer accepts response.
REQ-014 SHALL have port resp_rdata  output  32  extended load data; 0 for stores.
REQ-015 SHALL have port resp_err  output  1  access fault (see Configuration); tied 0 when feature excluded.

Function
REQ-016 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; one outstanding request at most.
REQ-017 SHALL drive req_ready=1 only in IDLE; request accepted on a cycle with req_valid && req_ready.
REQ-018 SHALL register addr, size, unsigned, write, wdata at accept; later input changes are ignored.
REQ-019 SHALL load a down-counter with LATENCY-1 at accept; WAIT decrements each cycle, enters RESP when counter is 0 (LATENCY=1: WAIT lasts 0 cycles, i.e. accept -> RESP directly).
REQ-020 SHALL assert resp_valid in RESP exactly LATENCY cycles after the accept cycle and hold resp_valid, resp_rdata, resp_err stable until resp_ready=1.
REQ-021 SHALL return to IDLE on the cycle after resp_valid && resp_ready; back-to-back request accepted no earlier than that IDLE cycle.
REQ-022 SHALL commit a store to memory on the clock edge that enters RESP; a load SHALL read memory on that same edge.
REQ-023 SHALL compute word index = req_addr[31:2] modulo MEM_DEPTH, byte lane = req_addr[1:0], little-endian.
REQ-024 SHALL, for byte store, write only lane addr[1:0]; halfword store, lanes {addr[1],0} and {addr[1],1}; word store, all four lanes; other lanes unchanged.
REQ-025 SHALL, for loads, extract the addressed byte/halfword/word and extend to 32 bits per req_unsigned; word loads unaffected by req_unsigned.
REQ-026 SHALL ignore misaligned low address bits when fault feature excluded (halfword uses addr[1] only, word uses no lane bits).
REQ-027 SHALL keep resp_rdata=0 for stores and for faulted requests.

Reset
REQ-028 SHALL, while reset=1, force FSM to IDLE, counter to 0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=0.
REQ-029 SHALL clear all memory words to 0 while reset=1.
REQ-030 SHALL discard an in-flight request (including an uncommitted store) on reset mid-operation; req_ready=1 the first cycle after reset deasserts.

Configuration
REQ-031 SHALL compile access-fault detection only when macro MULTICYCLE_DMEM_FAULT_EN is defined.
REQ-032 SHALL, with MULTICYCLE_DMEM_FAULT_EN, flag fault when halfword with addr[0]=1, word with addr[1:0]!=0, or addr[31:2] >= MEM_DEPTH; faulted request performs no memory write, returns resp_rdata=0, resp_err=1, same latency.
REQ-033 SHALL, without MULTICYCLE_DMEM_FAULT_EN, wrap out-of-range addresses per REQ-023, align per REQ-026, and tie resp_err to 0.

Verification
REQ-034 SHALL verify: LATENCY=2, store word 0xDEADBEEF @0x10 accepted cycle T -> resp_valid at T+2; load word @0x10 -> resp_rdata 0xDEADBEEF.
REQ-035 SHALL verify: after REQ-034, store byte 0x5A @0x13, load byte signed @0x13 -> 0x0000005A; load word @0x10 -> 0x5AADBEEF; store byte 0x80 @0x11, load byte signed @0x11 -> 0xFFFFFF80, unsigned -> 0x00000080.
REQ-036 SHALL verify: resp_ready held 0 for 3 cycles -> resp_valid/rdata stable, req_ready=0 throughout; req_ready=1 cycle after handshake.
REQ-037 SHALL verify: reset asserted one cycle after accepting a store 0x12345678 @0x20 -> after reset, load @0x20 returns 0x00000000.
REQ-038 SHALL verify: with MULTICYCLE_DMEM_FAULT_EN, word store 0x11111111 @0x22 -> resp_err=1, word @0x20 unchanged; without macro, same store writes word @0x20 = 0x11111111, resp_err=0.
REQ-039 SHALL verify: LATENCY=1, MEM_DEPTH=16, load @0x44 without macro -> returns word @0x04.
